// File: rtl/qwi12_petaled_pkg.sv
// Shared constants, counter-width helper and per-channel debounce state for the button capture path.
package qwi12_petaled_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_W_MAX           = 32;

    function automatic int cnt_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    // cnt is sized for the largest supported count; only the low cnt_w() bits ever toggle.
    typedef struct packed {
        logic                 sync1;
        logic                 sync2;
        logic                 level;
        logic [CNT_W_MAX-1:0] cnt;
    } btn_ch_t;

endpackage

// File: rtl/qwi12_btn_debounce.sv
// One button channel: two-flop synchronizer, hold-time debounce counter, level and edge pulses.
module qwi12_btn_debounce
    import qwi12_petaled_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    btn_ch_t ch_q, ch_d;
    logic    accept;

    always_comb begin
        ch_d       = ch_q;
        ch_d.sync1 = btn_raw;
        ch_d.sync2 = ch_q.sync1;
        accept     = 1'b0;
        // Any return to the current level restarts the hold window.
        if (ch_q.sync2 == ch_q.level) begin
            ch_d.cnt = '0;
        end else if (ch_q.cnt == CNT_W_MAX'(DEBOUNCE_CYCLES - 1)) begin
            accept     = 1'b1;
            ch_d.level = ch_q.sync2;
            ch_d.cnt   = '0;
        end else begin
            ch_d.cnt = CNT_W_MAX'(CNT_W'(ch_q.cnt + 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            ch_q <= ch_d;
            rise <= accept & ch_q.sync2;
            fall <= accept & ~ch_q.sync2;
        end
    end

    assign level = ch_q.level;

endmodule

// File: rtl/qwi12_btn_capture.sv
// Debounced button capture: per-channel debounce instances plus sticky pending flags and irq.
module qwi12_btn_capture
    import qwi12_petaled_pkg::*;
#(
    parameter int N_IN            = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int IRQ_ON_FALL     = 0,
    parameter int CNT_W           = cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] btn_raw,
    input  logic [N_IN-1:0] evt_clr,
    output logic [N_IN-1:0] btn_level,
    output logic [N_IN-1:0] btn_rise,
    output logic [N_IN-1:0] btn_fall,
    output logic [N_IN-1:0] evt_pend,
    output logic            irq
);

    logic [N_IN-1:0] clr_d;
    logic [N_IN-1:0] clr_edge;
    logic [N_IN-1:0] set_ev;

    qwi12_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb [N_IN-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .level   (btn_level),
        .rise    (btn_rise),
        .fall    (btn_fall)
    );

    assign clr_edge = evt_clr & ~clr_d;
    assign set_ev   = (IRQ_ON_FALL != 0) ? (btn_rise | btn_fall) : btn_rise;

    // Set has priority over clear so an event arriving with the clear is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_d    <= '0;
            evt_pend <= '0;
            irq      <= 1'b0;
        end else begin
            clr_d    <= evt_clr;
            evt_pend <= set_ev | (evt_pend & ~clr_edge);
            irq      <= |evt_pend;
        end
    end

endmodule
